// File: rtl/list_pkg.sv
// Shared types and header layout for the list packet path (packer and cache).
package list_pkg;

    localparam int DW = 32;
    localparam int FS = 4;
    localparam int BS = 2;

    localparam int HDR_MARK_BIT = 0;
    localparam int HDR_SEQ_LSB  = 1;
    localparam int HDR_SEQ_W    = 8;
    localparam int HDR_CNT_LSB  = 9;
    localparam int HDR_CNT_W    = 3;

    // fill index spans 0..FS-2; keep at least one bit when FS == 2
    localparam int FILL_W = (FS > 2) ? $clog2(FS - 1) : 1;
    localparam int CNT_W  = $clog2(BS + 1);

    typedef logic [DW-1:0]          word_t;
    typedef logic [FS-1:0][DW-1:0]  packet_t;

    // Header word: marker, sequence number, payload count (saturated to the field).
    function automatic word_t make_header(input logic [HDR_SEQ_W-1:0] seq,
                                          input int unsigned n_words);
        word_t                h;
        logic [HDR_CNT_W-1:0] cnt;
        if (n_words > (2**HDR_CNT_W) - 1)
            cnt = '1;
        else
            cnt = n_words[HDR_CNT_W-1:0];
        h = '0;
        h[HDR_MARK_BIT]                = 1'b1;
        h[HDR_SEQ_LSB +: HDR_SEQ_W]    = seq;
        h[HDR_CNT_LSB +: HDR_CNT_W]    = cnt;
        return h;
    endfunction

endpackage

// File: rtl/list_packer_if.sv
// Word-in / packet-out handshake bundle for list_packer.
interface list_packer_if;
    import list_pkg::*;

    word_t   IN;
    logic    i_valid;
    logic    o_ready;
    packet_t OUT;
    logic    o_valid;
    logic    i_ready;

    modport slave  (input  IN, i_valid, i_ready, output o_ready, OUT, o_valid);
    modport master (output IN, i_valid, i_ready, input  o_ready, OUT, o_valid);

endinterface

// File: rtl/list_packet_fifo.sv
// BS-deep packet FIFO; slot 0 is always the head so the output is a plain register.
module list_packet_fifo
    import list_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  packet_t push_data,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output packet_t head
);

    packet_t            slots_q [BS];
    packet_t            slots_d [BS];
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   wr_idx;
    logic               do_push;
    logic               do_pop;

    // Shift toward the head on pop, then write the new packet behind the last valid slot.
    always_comb begin
        slots_d = slots_q;
        count_d = count_q;
        do_pop  = pop  && (count_q != '0);
        do_push = push && (count_q != CNT_W'(BS));
        if (do_pop) begin
            for (int i = 0; i < BS - 1; i++)
                slots_d[i] = slots_q[i+1];
            slots_d[BS-1] = '0;
        end
        wr_idx = count_q - CNT_W'(do_pop);
        if (do_push) begin
            for (int i = 0; i < BS; i++)
                if (wr_idx == CNT_W'(i))
                    slots_d[i] = push_data;
        end
        if (do_push && !do_pop)
            count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push)
            count_d = count_q - CNT_W'(1);
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < BS; i++)
                slots_q[i] <= '0;
        end else begin
            count_q <= count_d;
            slots_q <= slots_d;
        end
    end

    assign full  = (count_q == CNT_W'(BS));
    assign empty = (count_q == '0);
    assign head  = slots_q[0];

endmodule

// File: rtl/list_packer.sv
// Groups FS-1 payload words into header-prefixed list packets and queues them.
// Optional: define LIST_PACKER_FLUSH_EN to add i_flush, which commits a partial packet.
module list_packer
    import list_pkg::*;
(
    input logic CLK,
    input logic RESET,
`ifdef LIST_PACKER_FLUSH_EN
    input logic i_flush,
`endif
    list_packer_if.slave bus
);

    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [HDR_SEQ_W-1:0] seq_q, seq_d;
    packet_t              stage_q, stage_d;
    logic [FILL_W:0]      n_words;
    logic                 last_slot;
    logic                 accept;
    logic                 commit;
    logic                 fifo_full;
    logic                 fifo_empty;
    packet_t              fifo_head;
    packet_t              push_pkt;

    assign last_slot   = (fill_q == FILL_W'(FS - 2));
    // Only the word that would complete a packet waits for FIFO space.
    assign bus.o_ready = !RESET && !(fifo_full && last_slot);
    assign accept      = bus.i_valid && bus.o_ready;
    assign n_words     = {1'b0, fill_q} + (FILL_W+1)'(accept);

    // Staging write, commit decision and packet assembly.
    always_comb begin
        fill_d   = fill_q;
        seq_d    = seq_q;
        stage_d  = stage_q;
        push_pkt = '0;
        for (int k = 1; k < FS; k++)
            if (accept && (fill_q == FILL_W'(k - 1)))
                stage_d[k] = bus.IN;
        commit = accept && last_slot;
`ifdef LIST_PACKER_FLUSH_EN
        if (i_flush && !fifo_full && ((fill_q != '0) || accept))
            commit = 1'b1;
`endif
        // slots past the accepted count hold stale data from an older packet
        for (int k = 1; k < FS; k++)
            if (int'(n_words) >= k)
                push_pkt[k] = stage_d[k];
        push_pkt[0] = make_header(seq_q, int'(n_words));
        if (commit) begin
            fill_d = '0;
            seq_d  = seq_q + HDR_SEQ_W'(1);
        end else if (accept) begin
            fill_d = fill_q + FILL_W'(1);
        end
    end

    // Fill index, sequence counter and staging registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fill_q  <= '0;
            seq_q   <= '0;
            stage_q <= '0;
        end else begin
            fill_q  <= fill_d;
            seq_q   <= seq_d;
            stage_q <= stage_d;
        end
    end

    list_packet_fifo u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (commit),
        .push_data (push_pkt),
        .pop       (bus.o_valid && bus.i_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign bus.OUT     = fifo_head;
    assign bus.o_valid = !fifo_empty;

endmodule

// File: tb/tb_list_packer.sv
// Randomised and directed checks of list_packer against a queue-based packet model.
module tb_list_packer;
    import list_pkg::*;

    logic clk;
    logic rst;
`ifdef LIST_PACKER_FLUSH_EN
    logic i_flush;
`endif

    list_packer_if bus ();

    list_packer dut (
        .CLK     (clk),
        .RESET   (rst),
`ifdef LIST_PACKER_FLUSH_EN
        .i_flush (i_flush),
`endif
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        n_checks = 0;
    int        n_pass   = 0;
    int        cyc      = 0;
    word_t     cur [$];
    packet_t   exp_q [$];
    logic [7:0] seq_m;
    bit        hold_prev;
    packet_t   prev_out;
    word_t     pop_hdr_log [$];
    int        pop_cyc_log [$];

    task automatic check(input string tag, input packet_t got, input packet_t exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference packet: header from the word count and sequence, payload words in order.
    function automatic packet_t ref_pkt();
        packet_t p;
        int      n;
        p = '0;
        n = cur.size();
        p[0] = 32'h1 | (32'(seq_m) << 1) | (32'((n > 7) ? 7 : n) << 9);
        for (int i = 0; i < n; i++)
            p[i+1] = cur[i];
        return p;
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.IN = '0;
`ifdef LIST_PACKER_FLUSH_EN
        i_flush = 1'b0;
`endif
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_o_ready", packet_t'(bus.o_ready), '0);
        check("rst_o_valid", packet_t'(bus.o_valid), '0);
        check("rst_out", bus.OUT, '0);
        rst = 1'b0;
        cur.delete();
        exp_q.delete();
        seq_m = '0;
        hold_prev = 1'b0;
    endtask

    task automatic do_cycle(input bit v, input word_t w, input bit r, input bit fl, output bit acc);
        bit exp_ready, exp_valid, full_m, pop, commit;
        @(negedge clk);
        bus.i_valid = v;
        bus.IN = w;
        bus.i_ready = r;
`ifdef LIST_PACKER_FLUSH_EN
        i_flush = fl;
`else
        if (fl) $display("note: flush requested in a build without flush support");
`endif
        #1;
        cyc++;
        full_m    = (exp_q.size() >= BS);
        exp_ready = !(full_m && (cur.size() == FS - 2));
        exp_valid = (exp_q.size() != 0);
        check("o_ready", packet_t'(bus.o_ready), packet_t'(exp_ready));
        check("o_valid", packet_t'(bus.o_valid), packet_t'(exp_valid));
        if (exp_valid) check("out_pkt", bus.OUT, exp_q[0]);
        if (hold_prev) check("out_hold", bus.OUT, prev_out);
        acc  = v && bus.o_ready;
        pop  = bus.o_valid && r;
        hold_prev = bus.o_valid && !r;
        prev_out  = bus.OUT;
        if (pop) begin
            pop_hdr_log.push_back(bus.OUT[0]);
            pop_cyc_log.push_back(cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (acc) cur.push_back(w);
        commit = (cur.size() == FS - 1);
`ifdef LIST_PACKER_FLUSH_EN
        if (fl && !full_m && cur.size() > 0) commit = 1'b1;
`endif
        if (commit) begin
            exp_q.push_back(ref_pkt());
            cur.delete();
            seq_m++;
        end
    endtask

    task automatic send_word(input word_t w, input bit r);
        bit a;
        int t;
        t = 0;
        a = 1'b0;
        while (!a && t < 100) begin
            do_cycle(1'b1, w, r, 1'b0, a);
            t++;
        end
        if (!a) check("send_timeout", packet_t'(a), packet_t'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit      a;
        int      accepted;
        int      budget;
        packet_t e;

        do_reset(2);

        // first packet and its header
        send_word(32'h11, 1'b1);
        send_word(32'h22, 1'b1);
        send_word(32'h33, 1'b1);
        do_cycle(1'b0, '0, 1'b0, 1'b0, a);
        check("first_hdr", packet_t'(bus.OUT[0]), packet_t'(32'h0000_0601));
        check("first_w1", packet_t'(bus.OUT[1]), packet_t'(32'h11));
        check("first_w3", packet_t'(bus.OUT[FS-1]), packet_t'(32'h33));

        // back-pressure: fill FIFO, stall completing word, then drain without bubbles
        do_reset(1);
        pop_hdr_log.delete();
        pop_cyc_log.delete();
        for (int i = 1; i <= 8; i++) send_word(word_t'(32'h100 + i), 1'b0);
        do_cycle(1'b1, 32'h109, 1'b0, 1'b0, a);
        check("stall_word9", packet_t'(a), '0);
        check("held_seq0", packet_t'(bus.OUT[0][8:1]), '0);
        send_word(32'h109, 1'b1);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, 1'b1, 1'b0, a);
        check("drain_count", packet_t'(pop_hdr_log.size()), packet_t'(3));
        for (int i = 0; i < pop_hdr_log.size() && i < 3; i++) begin
            check("drain_seq", packet_t'(pop_hdr_log[i][8:1]), packet_t'(i));
            check("drain_cyc", packet_t'(pop_cyc_log[i] - pop_cyc_log[0]), packet_t'(i));
        end

        // sequence wrap over 257 packets
        do_reset(1);
        pop_hdr_log.delete();
        budget = 0;
        while (pop_hdr_log.size() < 257 && budget < 3000) begin
            do_cycle(1'b1, word_t'($urandom), 1'b1, 1'b0, a);
            budget++;
        end
        check("wrap_count", packet_t'(pop_hdr_log.size() >= 257), packet_t'(1));
        for (int i = 0; i < pop_hdr_log.size() && i < 257; i++)
            check("wrap_seq", packet_t'(pop_hdr_log[i][8:1]), packet_t'(i % 256));

        // random valid/ready traffic against the model
        do_reset(1);
        accepted = 0;
        budget = 0;
        while (accepted < 1000 && budget < 20000) begin
            bit fl;
            fl = 1'b0;
`ifdef LIST_PACKER_FLUSH_EN
            fl = ($urandom % 16) == 0;
`endif
            do_cycle(($urandom % 4) != 0, word_t'($urandom), ($urandom % 3) != 0, fl, a);
            if (a) accepted++;
            budget++;
        end
        check("random_done", packet_t'(accepted), packet_t'(1000));
        for (int i = 0; i < 2 * BS + 2; i++) do_cycle(1'b0, '0, 1'b1, 1'b0, a);

        // reset mid-packet with a queued packet
        do_reset(1);
        for (int i = 0; i < 5; i++) send_word(word_t'(32'h200 + i), 1'b0);
        do_reset(1);
        send_word(32'h301, 1'b0);
        send_word(32'h302, 1'b0);
        send_word(32'h303, 1'b0);
        do_cycle(1'b0, '0, 1'b0, 1'b0, a);
        check("post_rst_hdr", packet_t'(bus.OUT[0]), packet_t'(32'h0000_0601));
        check("post_rst_w1", packet_t'(bus.OUT[1]), packet_t'(32'h301));
        do_cycle(1'b0, '0, 1'b1, 1'b0, a);

`ifdef LIST_PACKER_FLUSH_EN
        // partial packet flush
        do_reset(1);
        do_cycle(1'b1, 32'hAA, 1'b0, 1'b0, a);
        do_cycle(1'b0, '0, 1'b0, 1'b1, a);
        do_cycle(1'b0, '0, 1'b0, 1'b0, a);
        e = '0;
        e[0] = 32'h0000_0201;
        e[1] = 32'hAA;
        check("flush_pkt", bus.OUT, e);
`else
        e = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/list_packer.md
Name: list_packer

Overview:
- Transmit-side counterpart of the list caching path.
- Accepts a ready/valid stream of DW-bit payload words and groups each FS-1 consecutive words into one FS-word list packet.
- Word 0 of each packet is a header: marker bit, sequence number, word count.
- Finished packets queue in a BS-deep packet FIFO and are presented on a packet-wide ready/valid output that feeds the list cache input.

Parameters:
- DW, 32, payload word width; must be >= 16.
- FS, 4, fetch size: words per packet including the header; payload = FS-1 words; must be >= 2.
- BS, 2, packet FIFO depth in packets; must be >= 1.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- IN  input  DW  payload word.
- i_valid  input  1  IN valid.
- o_ready  output  1  word accepted when i_valid && o_ready.
- OUT  output  FS*DW (packed [FS-1:0][DW-1:0])  packet; OUT[0] is the header.
- o_valid  output  1  OUT holds a complete packet.
- i_ready  input  1  downstream takes packet when o_valid && i_ready.

Behaviour:
- Clocking/reset: one clock, CLK; reset is synchronous and active-high on RESET.
- Reset values:
  - OUT=0, o_valid=0, o_ready=0 while RESET is high.
  - fill index=0, sequence=0, FIFO empty.
  - o_ready=1 on the first cycle after reset release.
- Staging:
  - A fill index 0..FS-2 selects the staging slot.
  - Each accepted word is written to staging slot fill_idx+1; the first word of a packet lands in OUT[1], the last in OUT[FS-1].
  - fill_idx increments on accept and wraps to 0 after FS-2.
- Commit:
  - Accepting the word at fill_idx==FS-2 pushes the packet into the FIFO in the same cycle.
  - The pushed packet is the staging words plus that word plus the header.
- Header, OUT[0]:
  - bit0 = 1 (packet marker).
  - bits[8:1] = 8-bit sequence number; increments per committed packet and wraps 255->0.
  - bits[11:9] = payload word count = FS-1 (saturating at 7 in the field).
  - All higher bits are 0.
- o_ready = !RESET && !(fifo_full && fill_idx==FS-2).
  - Partial words are still accepted while the FIFO is full; only the completing word is stalled.
  - o_ready has no combinational dependence on i_ready or i_valid.
- Output side:
  - o_valid = FIFO not empty; OUT = FIFO head, registered with no combinational path from IN.
  - Latency: completing word accepted at cycle t -> o_valid=1 with that packet at t+1.
  - While o_valid && !i_ready, OUT and o_valid are held stable.
- Pop: o_valid && i_ready advances the head. The next packet, if present, appears the following cycle with no bubble.
- Simultaneous push and pop:
  - When the FIFO is not full, count is unchanged.
  - When full, push is blocked by o_ready that cycle; the freed slot is usable the next cycle.
- Empty FIFO with push: o_valid rises the next cycle; no bypass.
- RESET mid-packet or with a full FIFO: partial staging data and queued packets are discarded; sequence restarts at 0.

Optional Feature:
- Macro: LIST_PACKER_FLUSH_EN.
- With the macro, an extra input i_flush (1 bit) is present:
  - When i_flush=1 and fill_idx>0 (and o_ready would be 1), the partial packet commits that cycle.
  - Unfilled slots are zero; header bits[11:9] = number of words actually accepted, including a word accepted in the same cycle.
  - fill_idx returns to 0.
  - i_flush with fill_idx==0 and no accept is ignored.
  - i_flush with the FIFO full is held off until a slot frees.
- Without the macro, there is no i_flush port and every packet carries FS-1 words.

Decomposition:
- Package list_pkg:
  - localparams FS, BS, HDR_MARK_BIT=0, HDR_SEQ_LSB=1, HDR_SEQ_W=8, HDR_CNT_LSB=9, HDR_CNT_W=3.
  - typedef word_t (logic [DW-1:0]) and packet_t (logic [FS-1:0][DW-1:0]).
  - Shared with list_cache.
- One sub-module, list_packet_fifo:
  - BS-deep FIFO of packet_t with push/pop/full/empty and a registered head output.
  - list_packer instantiates it and owns the staging and header logic.

Test Plan:
- Reset then stream 0x11,0x22,0x33 with i_ready=1 -> one cycle after 0x33 accepted: o_valid=1, OUT[1..3]=0x11,0x22,0x33, OUT[0]=0x00000601 (count 3, seq 0, marker).
- i_ready=0, stream 9 words -> packets 0 and 1 queued; words 7 and 8 accepted; word 9 stalled (o_ready=0); OUT stable at seq 0. Raise i_ready -> seq 0, 1, 2 in consecutive cycles with no bubble.
- Continuous traffic for 257 packets -> header seq field reads 0,1,...,255,0,1.
- Toggle i_valid and i_ready pseudo-randomly for 1000 words -> packets match a scoreboard in order; no loss or duplication; OUT never changes while o_valid && !i_ready.
- Assert RESET after 2 words with one packet queued -> o_valid=0 the next cycle; the next packet carries seq 0 and only post-reset words.
- With LIST_PACKER_FLUSH_EN: accept 0xAA, pulse i_flush -> packet OUT[1]=0xAA, OUT[2]=OUT[3]=0, header count=1.
